// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared CPU constants: datapath widths, reset PC, HALT opcode, fetch FSM
// encodings and the branch-control encodings produced by decode.
package pc_fetch_ctrl_pkg;

  localparam int          ADDR_WIDTH  = 16;
  localparam int          INSTR_WIDTH = 16;
  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam logic [3:0]  OPCODE_HALT = 4'hF;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam logic [1:0] BRANCH_NONE = 2'd0;
  localparam logic [1:0] BRANCH_BEQ  = 2'd1;
  localparam logic [1:0] BRANCH_BNE  = 2'd2;
  localparam logic [1:0] BRANCH_JMP  = 2'd3;

endpackage

// File: rtl/pc_fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register, one-cycle capture. Priority: rst, then flush
// (bubble, instr cleared), then stall (hold), else capture.
module ifid_reg #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] fetch_instr,
  input  logic [ADDR_WIDTH-1:0]  fetch_pc_plus1,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc_plus1,
  output logic                   valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= '0;
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      // pc_plus1 is left as-is: it is meaningless once valid drops
      instr <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      instr    <= fetch_instr;
      pc_plus1 <= fetch_pc_plus1;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC select, IF/ID ownership, redirect squash and HALT freeze; redirect lands next edge.
// Optional PC_FETCH_STATS_EN adds a saturating taken-redirect counter on taken_count.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = pc_fetch_ctrl_pkg::ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = pc_fetch_ctrl_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = pc_fetch_ctrl_pkg::RESET_PC,
  parameter logic [3:0]            OPCODE_HALT = pc_fetch_ctrl_pkg::OPCODE_HALT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [ADDR_WIDTH-1:0]  ifid_pc_plus1,
  output logic                   ifid_valid,
  output logic                   flush_idex,
  output logic                   halted,
  output logic [15:0]            taken_count
);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] target;
  logic                  running;
  logic                  redirect;
  logic                  apply_redirect;
  logic                  halt_detect;

  assign running        = (state == ST_RUN);
  assign redirect       = branch | jump;
  assign target         = branch ? branch_target : jump_target;
  assign apply_redirect = redirect & running;
  assign pc_plus1       = pc + ADDR_WIDTH'(1);

  // A redirect in the same cycle means the HALT in ID is wrong-path.
  assign halt_detect = running & ifid_valid & ~stall & ~redirect &
                       (ifid_instr[INSTR_WIDTH-1 -: 4] == OPCODE_HALT);

  assign flush_idex = apply_redirect;
  assign imem_addr  = pc;
  assign halted     = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (!running) begin
      pc <= pc;
    end else if (redirect) begin
      pc <= target;
    end else if (!stall) begin
      pc <= pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (halt_detect) begin
      state <= ST_HALTED;
    end
  end

  // While halted the register is flushed every cycle so nothing decodes.
  ifid_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_ifid_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (apply_redirect | ~running),
    .fetch_instr    (imem_data),
    .fetch_pc_plus1 (pc_plus1),
    .instr          (ifid_instr),
    .pc_plus1       (ifid_pc_plus1),
    .valid          (ifid_valid)
  );

`ifdef PC_FETCH_STATS_EN
  logic [15:0] taken_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (apply_redirect && (taken_cnt != 16'hFFFF)) begin
      taken_cnt <= taken_cnt + 16'd1;
    end
  end

  assign taken_count = taken_cnt;
`else
  assign taken_count = '0;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-control stage of the 16-bit pipelined CPU. It consumes the `branch` decision from the branch comparator and the branch/jump targets from the execute stage. Each cycle it selects the next PC, drives the instruction-memory address, and owns the IF/ID pipeline register. On a redirect it squashes wrong-path instructions, and a decoded HALT freezes it.

## Interface
- `ADDR_WIDTH`, 16: PC and target width (word addressed).
- `INSTR_WIDTH`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `OPCODE_HALT`, 4'hF: value of instr[15:12] that means HALT.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard-unit hold; freeze PC and IF/ID.
- `branch` in 1: taken-branch decision from the branch comparator (EX stage).
- `branch_target` in ADDR_WIDTH: redirect address for a taken branch.
- `jump` in 1: unconditional jump resolved in EX.
- `jump_target` in ADDR_WIDTH: redirect address for a jump.
- `imem_data` in INSTR_WIDTH: instruction read at `imem_addr` (combinational memory).
- `imem_addr` out ADDR_WIDTH: current PC.
- `ifid_instr` out INSTR_WIDTH: registered instruction for decode.
- `ifid_pc_plus1` out ADDR_WIDTH: registered PC+1 of that instruction.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `flush_idex` out 1: combinational; squash ID/EX this cycle.
- `halted` out 1: core is halted.
- `taken_count` out 16: taken-redirect counter (only with the macro below).

## Operation
- State machine `RUN` / `HALTED`; reset → `RUN`.
- `redirect = branch | jump`. Target is `branch_target` if `branch`, else `jump_target`; branch has priority when both are asserted.
- PC next-value priority: rst → RESET_PC; HALTED → hold; redirect → target; stall → hold; else PC+1.
- PC+1 wraps modulo 2^ADDR_WIDTH (16'hFFFF → 16'h0000); no overflow flag.
- IF/ID update on redirect: `ifid_valid` ← 0 and instr ← 16'h0000, regardless of stall.
- IF/ID update on stall without redirect: hold all fields.
- IF/ID update otherwise: capture `imem_data` and PC+1, with `ifid_valid` ← 1.
- `flush_idex = redirect & (state == RUN)`. It kills the instruction in ID so it does not enter EX.
- HALT detect: in `RUN`, when `ifid_valid & ~stall & ~redirect & ifid_instr[15:12]==OPCODE_HALT`, go to `HALTED`.
- A redirect in the same cycle as a HALT detect wins, because the HALT is wrong-path. State stays `RUN`.
- In `HALTED`: PC frozen, `ifid_valid` ← 0, branch/jump/stall ignored, `flush_idex` = 0. Only `rst` exits.

## Timing
- Reset values after the first edge with `rst`=1:
  - `imem_addr`=RESET_PC
  - `ifid_instr`=0
  - `ifid_pc_plus1`=0
  - `ifid_valid`=0
  - `halted`=0
  - `taken_count`=0
- Fetch latency: an instruction at PC appears on `ifid_*` one edge after PC is presented.
- Branch penalty: `branch` in cycle N causes:
  - `imem_addr`=target in N+1;
  - `ifid_valid`=0 in N+1;
  - the target instruction valid in IF/ID in N+2.
  - Exactly two squashed slots: one through `flush_idex` in N, one through the IF/ID bubble.
- `rst` asserted mid-operation overrides everything on that edge, including redirect and HALTED.
- `halted` rises on the edge following HALT detect.

## Configuration
- `PC_FETCH_STATS_EN` defined:
  - `taken_count` increments on every edge where `redirect` is applied in `RUN`.
  - It saturates at 16'hFFFF and is cleared by `rst`.
- `PC_FETCH_STATS_EN` undefined: the counter register is absent and `taken_count` is tied to 0.

## Structure
- Shared CPU package/header holds:
  - ADDR_WIDTH, INSTR_WIDTH, RESET_PC, OPCODE_HALT;
  - the state encodings `ST_RUN`=1'b0 and `ST_HALTED`=1'b1;
  - the BRANCH_* control encodings used upstream.
- One natural sub-module, `ifid_reg`: the IF/ID register with `stall`-hold and `flush`-clear inputs. PC logic and the FSM stay in the top.

## Test plan
- Reset then free-run, `imem_data`=16'h1234, no stall:
  - `imem_addr` goes 0,1,2,3;
  - `ifid_pc_plus1` goes 1,2,3 one cycle behind;
  - `ifid_valid`=1 from cycle 2.
- At PC=5 assert `branch` for one cycle with `branch_target`=16'h0040:
  - `flush_idex`=1 that cycle;
  - next cycle `imem_addr`=16'h0040 and `ifid_valid`=0;
  - the cycle after, `ifid_pc_plus1`=16'h0041 and valid.
- Hold `stall` for 3 cycles at PC=8: PC stays 8 and IF/ID holds. Then `stall` with `branch` (target 16'h0100): PC=16'h0100 and IF/ID squashed.
- `branch` and `jump` together (targets 16'h0010 / 16'h0020): PC=16'h0010.
- HALT (16'hF000) reaches IF/ID:
  - `halted`=1 next cycle and PC frozen;
  - later `branch` is ignored;
  - `rst` restores PC=0 and `halted`=0.
- Start at PC=16'hFFFF: next PC=16'h0000.
- With `PC_FETCH_STATS_EN`: 3 redirects give `taken_count`=3.
